multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style main control unit for the multicycle MIPS datapath.
- Sequences fetch/decode/execute/memory/write-back for a fixed instruction subset by driving every datapath write enable, mux select and ALU op.
- Sequences the multiplier start/wait handshake.
- Runs the exception entry sequence: EPC save, then vector fetch from memory bytes 253/254.

Parameters:
ALUOP_PASS, 4'b0000, ALU passes SrcA
ALUOP_ADD, 4'b0001, ALU add
ALUOP_SUB, 4'b0010, ALU subtract
ALUOP_AND, 4'b0011, ALU bitwise and

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
overflow  in  1  ALU overflow, combinational in current cycle
zero  in  1  ALU zero, combinational in current cycle
mult_end  in  1  multiplier done pulse
PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w, mult_control  out  1 each  write enables / multiplier start
M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG, M_EXC  out  2 each  mux selects
ALUOp  out  4  ALU operation
state_dbg  out  5  current state encoding, for verification

Behaviour:
- Mux encodings:
  - M_PC: 00 ALU result, 01 ALUOut reg, 10 jump target, 11 EPC.
  - M_MEM: 00 PC, 01 ALUOut reg, 11 exception address.
  - M_ALUSrcA: 00 PC, 01 A, 10 MEM_out.
  - M_ALUSrcB: 00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2.
  - M_WREG: 00 rt, 01 rd.
  - M_EXC: 00 -> addr 253 (invalid opcode), 01 -> addr 254 (overflow).
- Output defaults: all outputs 0 in every state unless listed.
- Outputs are decoded from the registered state only, except the conditional PC_w in BR and the branch-out of R_EXEC/I_EXEC on overflow.
- Reset:
  - reset=1 at an edge: state <= RESET.
  - While reset is high, all outputs are forced 0 combinationally, so no write strobe fires in the reset cycle.
  - Reset mid-instruction abandons the instruction; no further PC/RB/MEM/EPC writes occur.
  - RESET -> FETCH unconditionally.
- Memory is synchronous with 1-cycle read latency; every read holds its address for 2 states.
- Fetch and decode:
  - FETCH: M_MEM=00; SrcA=00, SrcB=01, ADD; M_PC=00, PC_w=1 (PC <= PC+4; memory sees old PC).
  - FETCH_WAIT: M_MEM=00, IR_w=1.
  - DECODE: AB_w=1; SrcA=00, SrcB=11, ADD, ALUOut_w=1 (branch target precomputed).
- Dispatch from DECODE:
  - opcode 0x00 with funct 0x20/0x22/0x24 -> R_EXEC; funct 0x18 -> MULT_START.
  - 0x08 -> I_EXEC.
  - 0x23 / 0x2B -> ADDR.
  - 0x04 -> BR.
  - 0x02 -> JUMP.
  - Anything else -> EXC_EPC with code 00.
- R-type and immediate:
  - R_EXEC: SrcA=01, SrcB=00, ALUOp from funct (ADD/SUB/AND), ALUOut_w=1. If overflow and funct is add/sub -> EXC_EPC code 01, else R_WB.
  - R_WB: M_WREG=01, RB_w=1 -> FETCH.
  - I_EXEC: SrcA=01, SrcB=10, ADD, ALUOut_w=1. Overflow -> EXC_EPC code 01, else I_WB.
  - I_WB: M_WREG=00, RB_w=1 -> FETCH.
- Loads and stores:
  - ADDR: SrcA=01, SrcB=10, ADD, ALUOut_w=1 -> LW_RD (lw) or SW_WR (sw).
  - LW_RD: M_MEM=01.
  - LW_WAIT: M_MEM=01, MEM_DATA_REG_w=1.
  - LW_WB: M_WREG=00, RB_w=1 -> FETCH.
  - SW_WR: M_MEM=01, MEM_w=1 -> FETCH.
- Branch and jump:
  - BR: SrcA=01, SrcB=00, SUB; if zero, M_PC=01 and PC_w=1 -> FETCH.
  - JUMP: M_PC=10, PC_w=1 -> FETCH.
- Multiply:
  - MULT_START: mult_control=1 for exactly 1 cycle.
  - MULT_WAIT: hold until mult_end=1, then -> FETCH.
  - mult_end seen in MULT_START is ignored.
- Exception entry:
  - exc_code is a 2-bit register latched on entry to EXC_EPC.
  - EXC_EPC: SrcA=00, SrcB=01, SUB, ALUOut_w=1 (faulting PC = PC-4).
  - EXC_SAVE: EPC_w=1.
  - EXC_RD and EXC_WAIT: M_MEM=11, M_EXC=exc_code.
  - EXC_JMP: SrcA=10, ALUOp=PASS, M_PC=00, PC_w=1 (PC <= vector word) -> FETCH.
- Overflow rules: overflow outside R_EXEC/I_EXEC is ignored. On overflow, RB_w is never asserted for the faulting instruction.
- Cycle counts: R-type 5, addi 5, lw 7, sw 5, beq 4, j 4, exception path adds 5 after detection.

Test Plan:
- Reset held 3 cycles, released -> all outputs 0 during reset; state RESET then FETCH; PC_w=1 with ALUOp=0001 in the first FETCH.
- opcode=0x00, funct=0x20, overflow=0 -> DECODE, R_EXEC (ALUOp=0001), R_WB; RB_w=1 with M_WREG=01 exactly 1 cycle; back to FETCH 5 cycles after FETCH.
- opcode=0x08 with overflow=1 in I_EXEC -> no RB_w. EPC_w=1 in EXC_SAVE; M_MEM=11, M_EXC=01 in both EXC_RD and EXC_WAIT; PC_w=1 with M_ALUSrcA=10 in EXC_JMP.
- opcode=0x23 -> MEM_DATA_REG_w=1 in LW_WAIT, RB_w=1 with M_WREG=00 in LW_WB. opcode=0x2B -> MEM_w=1 with M_MEM=01 for exactly 1 cycle.
- opcode=0x04: zero=1 -> PC_w=1 with M_PC=01. zero=0 -> PC_w=0. opcode=0x3F -> exception path with M_EXC=00.
- funct=0x18 -> mult_control pulses 1 cycle; mult_end delayed 33 cycles keeps state at MULT_WAIT. Reset asserted in MULT_WAIT -> RESET next cycle, no PC_w/RB_w.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS main controller and its datapath.
// The controller side is the master; the datapath (including the multiplier) is the slave.
interface multicycle_ctrl_if;
    // Instruction fields and datapath status seen by the controller
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       zero;
    logic       mult_end;

    // Write enables and multiplier start
    logic       PC_w;
    logic       EPC_w;
    logic       MEM_w;
    logic       IR_w;
    logic       ALUOut_w;
    logic       RB_w;
    logic       AB_w;
    logic       MEM_DATA_REG_w;
    logic       mult_control;

    // Mux selects and ALU operation
    logic [1:0] M_PC;
    logic [1:0] M_MEM;
    logic [1:0] M_ALUSrcA;
    logic [1:0] M_ALUSrcB;
    logic [1:0] M_WREG;
    logic [1:0] M_EXC;
    logic [3:0] ALUOp;

    logic [4:0] state_dbg;

    // Multiplier handshake: mult_control is a single-cycle start pulse; mult_end is a
    // done pulse that is honoured only once the controller is waiting for it.
    modport master (
        input  opcode, funct, overflow, zero, mult_end,
        output PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w, mult_control,
        output M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG, M_EXC, ALUOp, state_dbg
    );

    modport slave (
        output opcode, funct, overflow, zero, mult_end,
        input  PC_w, EPC_w, MEM_w, IR_w, ALUOut_w, RB_w, AB_w, MEM_DATA_REG_w, mult_control,
        input  M_PC, M_MEM, M_ALUSrcA, M_ALUSrcB, M_WREG, M_EXC, ALUOp, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main control unit for the multicycle MIPS datapath: instruction sequencing,
// multiplier start/wait and the exception entry sequence (EPC save, vector fetch).
module multicycle_ctrl (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    localparam logic [3:0] ALUOP_PASS = 4'b0000;
    localparam logic [3:0] ALUOP_ADD  = 4'b0001;
    localparam logic [3:0] ALUOP_SUB  = 4'b0010;
    localparam logic [3:0] ALUOP_AND  = 4'b0011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_MULT = 6'h18;

    localparam logic [1:0] EXC_INVALID  = 2'b00;
    localparam logic [1:0] EXC_OVERFLOW = 2'b01;

    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JUMP    = 2'b10;
    localparam logic [1:0] MEM_ALUOUT = 2'b01;
    localparam logic [1:0] MEM_EXC    = 2'b11;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_A     = 2'b01;
    localparam logic [1:0] SRCA_MEM   = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BOFS  = 2'b11;
    localparam logic [1:0] WREG_RT    = 2'b00;
    localparam logic [1:0] WREG_RD    = 2'b01;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_R_EXEC     = 5'd4,
        S_R_WB       = 5'd5,
        S_I_EXEC     = 5'd6,
        S_I_WB       = 5'd7,
        S_ADDR       = 5'd8,
        S_LW_RD      = 5'd9,
        S_LW_WAIT    = 5'd10,
        S_LW_WB      = 5'd11,
        S_SW_WR      = 5'd12,
        S_BR         = 5'd13,
        S_JUMP       = 5'd14,
        S_MULT_START = 5'd15,
        S_MULT_WAIT  = 5'd16,
        S_EXC_EPC    = 5'd17,
        S_EXC_SAVE   = 5'd18,
        S_EXC_RD     = 5'd19,
        S_EXC_WAIT   = 5'd20,
        S_EXC_JMP    = 5'd21
    } state_t;

    typedef struct packed {
        logic       pc_w;
        logic       epc_w;
        logic       mem_w;
        logic       ir_w;
        logic       aluout_w;
        logic       rb_w;
        logic       ab_w;
        logic       mdr_w;
        logic       mult_control;
        logic [1:0] m_pc;
        logic [1:0] m_mem;
        logic [1:0] m_alusrca;
        logic [1:0] m_alusrcb;
        logic [1:0] m_wreg;
        logic [1:0] m_exc;
        logic [3:0] aluop;
    } ctl_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] exc_code;
    logic [1:0] exc_next;
    ctl_t       ctl_q;
    ctl_t       ctl_out;
    logic       br_taken;

    // Moore output table; evaluated on the next state so the outputs come straight off flops.
    function automatic ctl_t state_outputs(input state_t s, input logic [5:0] fn,
                                           input logic [1:0] code);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.m_alusrca = SRCA_PC;
                c.m_alusrcb = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.m_pc      = PC_ALU;
                c.pc_w      = 1'b1;
            end
            S_FETCH_WAIT: c.ir_w = 1'b1;
            S_DECODE: begin
                c.ab_w      = 1'b1;
                c.m_alusrcb = SRCB_BOFS;
                c.aluop     = ALUOP_ADD;
                c.aluout_w  = 1'b1;
            end
            S_R_EXEC: begin
                c.m_alusrca = SRCA_A;
                c.m_alusrcb = SRCB_B;
                c.aluout_w  = 1'b1;
                case (fn)
                    FN_SUB:  c.aluop = ALUOP_SUB;
                    FN_AND:  c.aluop = ALUOP_AND;
                    default: c.aluop = ALUOP_ADD;
                endcase
            end
            S_R_WB: begin
                c.m_wreg = WREG_RD;
                c.rb_w   = 1'b1;
            end
            S_I_EXEC, S_ADDR: begin
                c.m_alusrca = SRCA_A;
                c.m_alusrcb = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
                c.aluout_w  = 1'b1;
            end
            S_I_WB, S_LW_WB: begin
                c.m_wreg = WREG_RT;
                c.rb_w   = 1'b1;
            end
            S_LW_RD: c.m_mem = MEM_ALUOUT;
            S_LW_WAIT: begin
                c.m_mem = MEM_ALUOUT;
                c.mdr_w = 1'b1;
            end
            S_SW_WR: begin
                c.m_mem = MEM_ALUOUT;
                c.mem_w = 1'b1;
            end
            S_BR: begin
                c.m_alusrca = SRCA_A;
                c.m_alusrcb = SRCB_B;
                c.aluop     = ALUOP_SUB;
            end
            S_JUMP: begin
                c.m_pc = PC_JUMP;
                c.pc_w = 1'b1;
            end
            S_MULT_START: c.mult_control = 1'b1;
            S_EXC_EPC: begin
                // PC already points past the faulting instruction
                c.m_alusrca = SRCA_PC;
                c.m_alusrcb = SRCB_FOUR;
                c.aluop     = ALUOP_SUB;
                c.aluout_w  = 1'b1;
            end
            S_EXC_SAVE: c.epc_w = 1'b1;
            S_EXC_RD, S_EXC_WAIT: begin
                c.m_mem = MEM_EXC;
                c.m_exc = code;
            end
            S_EXC_JMP: begin
                c.m_alusrca = SRCA_MEM;
                c.aluop     = ALUOP_PASS;
                c.m_pc      = PC_ALU;
                c.pc_w      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next = state;
        exc_next   = exc_code;
        case (state)
            S_RESET:      state_next = S_FETCH;
            S_FETCH:      state_next = S_FETCH_WAIT;
            S_FETCH_WAIT: state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct == FN_ADD || bus.funct == FN_SUB || bus.funct == FN_AND) begin
                            state_next = S_R_EXEC;
                        end else if (bus.funct == FN_MULT) begin
                            state_next = S_MULT_START;
                        end else begin
                            state_next = S_EXC_EPC;
                            exc_next   = EXC_INVALID;
                        end
                    end
                    OP_ADDI:      state_next = S_I_EXEC;
                    OP_LW, OP_SW: state_next = S_ADDR;
                    OP_BEQ:       state_next = S_BR;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next = S_EXC_EPC;
                        exc_next   = EXC_INVALID;
                    end
                endcase
            end
            S_R_EXEC: begin
                // and cannot overflow; only add/sub trap
                if (bus.overflow && bus.funct != FN_AND) begin
                    state_next = S_EXC_EPC;
                    exc_next   = EXC_OVERFLOW;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_I_EXEC: begin
                if (bus.overflow) begin
                    state_next = S_EXC_EPC;
                    exc_next   = EXC_OVERFLOW;
                end else begin
                    state_next = S_I_WB;
                end
            end
            S_ADDR:       state_next = (bus.opcode == OP_LW) ? S_LW_RD : S_SW_WR;
            S_LW_RD:      state_next = S_LW_WAIT;
            S_LW_WAIT:    state_next = S_LW_WB;
            S_R_WB, S_I_WB, S_LW_WB, S_SW_WR, S_BR, S_JUMP, S_EXC_JMP:
                          state_next = S_FETCH;
            S_MULT_START: state_next = S_MULT_WAIT;
            S_MULT_WAIT:  state_next = bus.mult_end ? S_FETCH : S_MULT_WAIT;
            S_EXC_EPC:    state_next = S_EXC_SAVE;
            S_EXC_SAVE:   state_next = S_EXC_RD;
            S_EXC_RD:     state_next = S_EXC_WAIT;
            S_EXC_WAIT:   state_next = S_EXC_JMP;
            default:      state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RESET;
            exc_code <= EXC_INVALID;
            ctl_q    <= '0;
        end else begin
            state    <= state_next;
            exc_code <= exc_next;
            ctl_q    <= state_outputs(state_next, bus.funct, exc_next);
        end
    end

    // Branch decision uses the live zero flag; reset silences every strobe in its own cycle.
    assign br_taken = (state == S_BR) && bus.zero;

    always_comb begin
        ctl_out = ctl_q;
        if (br_taken) begin
            ctl_out.pc_w = 1'b1;
            ctl_out.m_pc = PC_ALUOUT;
        end
        if (reset) begin
            ctl_out = '0;
        end
    end

    assign bus.PC_w           = ctl_out.pc_w;
    assign bus.EPC_w          = ctl_out.epc_w;
    assign bus.MEM_w          = ctl_out.mem_w;
    assign bus.IR_w           = ctl_out.ir_w;
    assign bus.ALUOut_w       = ctl_out.aluout_w;
    assign bus.RB_w           = ctl_out.rb_w;
    assign bus.AB_w           = ctl_out.ab_w;
    assign bus.MEM_DATA_REG_w = ctl_out.mdr_w;
    assign bus.mult_control   = ctl_out.mult_control;
    assign bus.M_PC           = ctl_out.m_pc;
    assign bus.M_MEM          = ctl_out.m_mem;
    assign bus.M_ALUSrcA      = ctl_out.m_alusrca;
    assign bus.M_ALUSrcB      = ctl_out.m_alusrcb;
    assign bus.M_WREG         = ctl_out.m_wreg;
    assign bus.M_EXC          = ctl_out.m_exc;
    assign bus.ALUOp          = ctl_out.aluop;
    assign bus.state_dbg      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected control traces built from the
// instruction rules, a vector table, random instructions and reset corner sequences.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_w;
        logic       epc_w;
        logic       mem_w;
        logic       ir_w;
        logic       aluout_w;
        logic       rb_w;
        logic       ab_w;
        logic       mdr_w;
        logic       mult_control;
        logic [1:0] m_pc;
        logic [1:0] m_mem;
        logic [1:0] m_alusrca;
        logic [1:0] m_alusrcb;
        logic [1:0] m_wreg;
        logic [1:0] m_exc;
        logic [3:0] aluop;
    } ctl_t;

    localparam int CTL_W = $bits(ctl_t);
    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       ovf;
        logic       zr;
        int         md;
        logic       eis;
        int         cycles;
    } vec_t;

    logic clk;
    logic reset;
    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [CTL_W-1:0] exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [4:0] reset_code;
    logic [4:0] fetch_code;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic ctl_t dut_ctl();
        ctl_t c;
        c.pc_w         = bus.PC_w;
        c.epc_w        = bus.EPC_w;
        c.mem_w        = bus.MEM_w;
        c.ir_w         = bus.IR_w;
        c.aluout_w     = bus.ALUOut_w;
        c.rb_w         = bus.RB_w;
        c.ab_w         = bus.AB_w;
        c.mdr_w        = bus.MEM_DATA_REG_w;
        c.mult_control = bus.mult_control;
        c.m_pc         = bus.M_PC;
        c.m_mem        = bus.M_MEM;
        c.m_alusrca    = bus.M_ALUSrcA;
        c.m_alusrcb    = bus.M_ALUSrcB;
        c.m_wreg       = bus.M_WREG;
        c.m_exc        = bus.M_EXC;
        c.aluop        = bus.ALUOp;
        return c;
    endfunction

    function automatic ctl_t alu_sel(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op);
        ctl_t c;
        c = '0;
        c.m_alusrca = a;
        c.m_alusrcb = b;
        c.aluop     = op;
        return c;
    endfunction

    function automatic ctl_t fetch_ctl();
        ctl_t c;
        c = alu_sel(2'b00, 2'b01, ALU_ADD);
        c.pc_w = 1'b1;
        return c;
    endfunction

    task automatic chk_ctl(input string name, input ctl_t exp);
        ctl_t act;
        act = dut_ctl();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model: cycle trace of one instruction ----------------
    task automatic push_exc(input logic [1:0] code);
        ctl_t c;
        c = alu_sel(2'b00, 2'b01, ALU_SUB); c.aluout_w = 1'b1; exp_q.push_back(c);
        c = '0; c.epc_w = 1'b1;                                 exp_q.push_back(c);
        c = '0; c.m_mem = 2'b11; c.m_exc = code;                exp_q.push_back(c);
        exp_q.push_back(c);
        c = alu_sel(2'b10, 2'b00, ALU_PASS); c.pc_w = 1'b1;     exp_q.push_back(c);
    endtask

    task automatic build_trace(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                               input logic zr, input int md);
        ctl_t c;
        logic [3:0] rop;
        exp_q.delete();
        exp_q.push_back(fetch_ctl());
        c = '0; c.ir_w = 1'b1; exp_q.push_back(c);
        c = alu_sel(2'b00, 2'b11, ALU_ADD); c.ab_w = 1'b1; c.aluout_w = 1'b1; exp_q.push_back(c);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            rop = (fn == 6'h22) ? ALU_SUB : (fn == 6'h24) ? ALU_AND : ALU_ADD;
            c = alu_sel(2'b01, 2'b00, rop); c.aluout_w = 1'b1; exp_q.push_back(c);
            if (ovf && fn != 6'h24) push_exc(2'b01);
            else begin c = '0; c.m_wreg = 2'b01; c.rb_w = 1'b1; exp_q.push_back(c); end
        end else if (op == 6'h00 && fn == 6'h18) begin
            c = '0; c.mult_control = 1'b1; exp_q.push_back(c);
            for (int i = 0; i < md; i++) exp_q.push_back('0);
        end else if (op == 6'h08) begin
            c = alu_sel(2'b01, 2'b10, ALU_ADD); c.aluout_w = 1'b1; exp_q.push_back(c);
            if (ovf) push_exc(2'b01);
            else begin c = '0; c.rb_w = 1'b1; exp_q.push_back(c); end
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = alu_sel(2'b01, 2'b10, ALU_ADD); c.aluout_w = 1'b1; exp_q.push_back(c);
            if (op == 6'h23) begin
                c = '0; c.m_mem = 2'b01;               exp_q.push_back(c);
                c = '0; c.m_mem = 2'b01; c.mdr_w = 1'b1; exp_q.push_back(c);
                c = '0; c.rb_w = 1'b1;                  exp_q.push_back(c);
            end else begin
                c = '0; c.m_mem = 2'b01; c.mem_w = 1'b1; exp_q.push_back(c);
            end
        end else if (op == 6'h04) begin
            c = alu_sel(2'b01, 2'b00, ALU_SUB);
            if (zr) begin c.pc_w = 1'b1; c.m_pc = 2'b01; end
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c = '0; c.m_pc = 2'b10; c.pc_w = 1'b1; exp_q.push_back(c);
        end else begin
            push_exc(2'b00);
        end
    endtask

    // ---------------- driver: run one instruction from the FETCH cycle ----------------
    // Entered and left at negedge+1 of a FETCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                             input logic zr, input int md, input logic eis, output int cycles);
        int  cyc;
        bit  done;
        build_trace(op, fn, ovf, zr, md);
        cyc  = 0;
        done = 0;
        while (!done) begin
            bus.opcode   = op;
            bus.funct    = fn;
            bus.overflow = ovf;
            bus.zero     = zr;
            bus.mult_end = (cyc == 3 + md) || (eis && cyc == 3);
            #1;
            if (cyc < exp_q.size())
                chk_ctl($sformatf("trace op=%h fn=%h ovf=%0d z=%0d cyc=%0d", op, fn, ovf, zr, cyc),
                        ctl_t'(exp_q[cyc]));
            else
                chk_val($sformatf("overrun op=%h fn=%h cyc", op, fn), cyc, exp_q.size() - 1);
            step();
            cyc++;
            if (bus.state_dbg == fetch_code || cyc >= 80) done = 1;
        end
        bus.mult_end = 1'b0;
        cycles = cyc;
    endtask

    task automatic reset_recover(input string tag);
        step();
        reset = 1'b0;
        bus.mult_end = 1'b0;
        #1;
        chk_ctl({tag, "_reset_state_outs"}, '0);
        chk_val({tag, "_reset_state"}, int'(bus.state_dbg), int'(reset_code));
        step();
        chk_ctl({tag, "_refetch_outs"}, fetch_ctl());
        chk_val({tag, "_refetch_state"}, int'(bus.state_dbg), int'(fetch_code));
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[16];
    int   cycles;
    logic [4:0] wait_code;
    logic [5:0] ops[7];
    logic [5:0] fns[5];

    initial begin
        vecs[0]  = '{6'h00, 6'h20, 1'b0, 1'b0, 0, 1'b0, 5};
        vecs[1]  = '{6'h00, 6'h22, 1'b0, 1'b1, 0, 1'b0, 5};
        vecs[2]  = '{6'h00, 6'h24, 1'b1, 1'b0, 0, 1'b0, 5};
        vecs[3]  = '{6'h00, 6'h20, 1'b1, 1'b0, 0, 1'b0, 9};
        vecs[4]  = '{6'h00, 6'h22, 1'b1, 1'b0, 0, 1'b0, 9};
        vecs[5]  = '{6'h08, 6'h00, 1'b0, 1'b0, 0, 1'b0, 5};
        vecs[6]  = '{6'h08, 6'h15, 1'b1, 1'b0, 0, 1'b0, 9};
        vecs[7]  = '{6'h23, 6'h00, 1'b1, 1'b1, 0, 1'b0, 7};
        vecs[8]  = '{6'h2B, 6'h20, 1'b0, 1'b0, 0, 1'b0, 5};
        vecs[9]  = '{6'h04, 6'h00, 1'b0, 1'b1, 0, 1'b0, 4};
        vecs[10] = '{6'h04, 6'h00, 1'b1, 1'b0, 0, 1'b0, 4};
        vecs[11] = '{6'h02, 6'h00, 1'b0, 1'b1, 0, 1'b0, 4};
        vecs[12] = '{6'h3F, 6'h00, 1'b0, 1'b0, 0, 1'b0, 8};
        vecs[13] = '{6'h00, 6'h21, 1'b1, 1'b0, 0, 1'b0, 8};
        vecs[14] = '{6'h00, 6'h18, 1'b1, 1'b1, 33, 1'b0, 37};
        vecs[15] = '{6'h00, 6'h18, 1'b0, 1'b0, 1, 1'b1, 5};
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h18, 6'h00};

        reset        = 1'b1;
        bus.opcode   = 6'h00;
        bus.funct    = 6'h00;
        bus.overflow = 1'b0;
        bus.zero     = 1'b0;
        bus.mult_end = 1'b0;

        // Reset held for three edges; strobes must stay silent even with a taken-branch input
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) begin
                reset_code = bus.state_dbg;
                bus.opcode = 6'h04;
                bus.zero   = 1'b1;
                #1;
            end
            chk_ctl($sformatf("reset_outs_%0d", k), '0);
            chk_val($sformatf("reset_state_%0d", k), int'(bus.state_dbg), int'(reset_code));
        end
        reset = 1'b0;
        #1;
        chk_ctl("reset_state_outs", '0);
        step();
        chk_ctl("first_fetch", fetch_ctl());
        fetch_code = bus.state_dbg;
        chk_val("fetch_code_distinct", int'(fetch_code != reset_code), 1);

        // Table of instructions with their architected cycle counts
        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].ovf, vecs[i].zr, vecs[i].md, vecs[i].eis, cycles);
            chk_val($sformatf("cycles_vec%0d", i), cycles, vecs[i].cycles);
        end

        // Random instructions against the trace model
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int md;
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(0, 4)];
            if (fns[4] == fn) fn = 6'($urandom);
            md = $urandom_range(1, 6);
            run_instr(op, fn, 1'($urandom), 1'($urandom), md, 1'($urandom), cycles);
            chk_val($sformatf("cycles_rand%0d", i), cycles, exp_q.size());
        end

        // Reset while waiting on the multiplier, with mult_end arriving in the reset cycle
        bus.opcode   = 6'h00;
        bus.funct    = 6'h18;
        bus.overflow = 1'b0;
        bus.mult_end = 1'b0;
        step(); step(); step();
        begin
            ctl_t c;
            c = '0; c.mult_control = 1'b1;
            chk_ctl("mult_start_pulse", c);
        end
        step();
        chk_ctl("mult_wait_outs", '0);
        wait_code = bus.state_dbg;
        step();
        chk_val("mult_wait_hold", int'(bus.state_dbg), int'(wait_code));
        reset        = 1'b1;
        bus.mult_end = 1'b1;
        #1;
        chk_ctl("mult_reset_outs", '0);
        reset_recover("mult");

        // Reset in a taken branch must suppress the conditional PC write
        bus.opcode = 6'h04;
        bus.zero   = 1'b1;
        step(); step(); step();
        begin
            ctl_t c;
            c = alu_sel(2'b01, 2'b00, ALU_SUB); c.pc_w = 1'b1; c.m_pc = 2'b01;
            chk_ctl("br_taken_outs", c);
        end
        reset = 1'b1;
        #1;
        chk_ctl("br_reset_outs", '0);
        reset_recover("br");

        // One more instruction after recovery to confirm normal sequencing resumes
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 2, 1'b0, cycles);
        chk_val("cycles_after_reset_lw", cycles, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
